// File: rtl/mram_pkg.sv
// Shared types and constants for the serial MRAM sequencer.
package mram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WRITE_STROBE,
    RD_ACCESS,
    RD_LOAD,
    SHIFT_OUT,
    DONE
  } state_e;

  // MRAM strobes are active low; these are their idle levels.
  localparam logic CHIP_EN_OFF  = 1'b1;
  localparam logic WRITE_EN_OFF = 1'b1;
  localparam logic OUT_EN_OFF   = 1'b1;

  function automatic int unsigned ctr_width(input int unsigned addr_w,
                                            input int unsigned data_w,
                                            input int unsigned rd_len,
                                            input int unsigned wr_len);
    int unsigned m;
    m = addr_w;
    if (data_w > m) m = data_w;
    if (rd_len > m) m = rd_len;
    if (wr_len > m) m = wr_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mram_seq_ctrl_strobe_gen.sv
// Registered decode of the MRAM strobes from the sequencer's next state.
module mram_strobe_gen
  import mram_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  state_e           state_i,
  input  logic [LANES-1:0] mask_i,
  output logic             chip_en_o,
  output logic             write_en_o,
  output logic             out_en_o,
  output logic [LANES-1:0] byte_en_n_o
);

  logic             chip_en_d, write_en_d, out_en_d;
  logic [LANES-1:0] byte_en_n_d;

  always_comb begin
    chip_en_d   = CHIP_EN_OFF;
    write_en_d  = WRITE_EN_OFF;
    out_en_d    = OUT_EN_OFF;
    byte_en_n_d = '1;
    unique case (state_i)
      WRITE_STROBE: begin
        chip_en_d   = 1'b0;
        write_en_d  = 1'b0;
        byte_en_n_d = ~mask_i;
      end
      RD_ACCESS, RD_LOAD: begin
        chip_en_d   = 1'b0;
        out_en_d    = 1'b0;
        byte_en_n_d = ~mask_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_en_o   <= CHIP_EN_OFF;
      write_en_o  <= WRITE_EN_OFF;
      out_en_o    <= OUT_EN_OFF;
      byte_en_n_o <= '1;
    end else begin
      chip_en_o   <= chip_en_d;
      write_en_o  <= write_en_d;
      out_en_o    <= out_en_d;
      byte_en_n_o <= byte_en_n_d;
    end
  end

endmodule

// File: rtl/mram_seq_ctrl.sv
// Single-operation read/write sequencer between the serial front-end and MRAM pins.
module mram_seq_ctrl
  import mram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                read_write_sel,
  input  logic [DATA_W/8-1:0] byte_sel,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                data_en,
  output logic                addr_en,
  output logic                send_data,
  output logic                load,
  output logic                data_in_from_MRAM_en,
  output logic                chip_en,
  output logic                write_en,
  output logic                out_en,
  output logic [DATA_W/8-1:0] byte_en_n
);

  localparam int unsigned LANES    = DATA_W / 8;
  localparam int unsigned SHIFT_WR = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CW       = ctr_width(ADDR_W, DATA_W, RD_WAIT + 1, WR_PULSE);

  typedef logic [CW-1:0] cnt_t;

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             op_wr_q, op_wr_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             accept;
  logic busy_q, done_q, data_en_q, addr_en_q, send_q, load_q, pts_en_q;
  logic busy_d, done_d, data_en_d, addr_en_d, send_d, load_d, pts_en_d;

  assign accept  = (state_q == IDLE) && start && !abort;
  assign op_wr_d = accept ? read_write_sel : op_wr_q;
  assign mask_d  = accept ? ((byte_sel == '0) ? '1 : byte_sel) : mask_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (accept) state_d = SHIFT_IN;
      SHIFT_IN: begin
        if (op_wr_q && cnt_q == cnt_t'(SHIFT_WR - 1))      state_d = WRITE_STROBE;
        else if (!op_wr_q && cnt_q == cnt_t'(ADDR_W - 1))  state_d = RD_ACCESS;
      end
      WRITE_STROBE: if (cnt_q == cnt_t'(WR_PULSE - 1)) state_d = DONE;
      RD_ACCESS:    if (cnt_q == cnt_t'(RD_WAIT)) state_d = RD_LOAD;
      RD_LOAD:      state_d = SHIFT_OUT;
      SHIFT_OUT:    if (cnt_q == cnt_t'(DATA_W - 1)) state_d = DONE;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    addr_en_d = (state_d == SHIFT_IN) && (cnt_d < cnt_t'(ADDR_W));
    data_en_d = (state_d == SHIFT_IN) && op_wr_d && (cnt_d < cnt_t'(DATA_W));
    send_d    = (state_d == WRITE_STROBE) || (state_d == RD_ACCESS) || (state_d == SHIFT_OUT);
    load_d    = (state_d == RD_LOAD);
    pts_en_d  = (state_d == RD_LOAD) || (state_d == SHIFT_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      mask_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_en_q <= 1'b0;
      addr_en_q <= 1'b0;
      send_q    <= 1'b0;
      load_q    <= 1'b0;
      pts_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      mask_q    <= mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_en_q <= data_en_d;
      addr_en_q <= addr_en_d;
      send_q    <= send_d;
      load_q    <= load_d;
      pts_en_q  <= pts_en_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign data_en              = data_en_q;
  assign addr_en              = addr_en_q;
  assign send_data            = send_q;
  assign load                 = load_q;
  assign data_in_from_MRAM_en = pts_en_q;

  mram_strobe_gen #(
    .LANES(LANES)
  ) u_strobe (
    .clk        (clk),
    .rst_n      (rst_n),
    .state_i    (state_d),
    .mask_i     (mask_d),
    .chip_en_o  (chip_en),
    .write_en_o (write_en),
    .out_en_o   (out_en),
    .byte_en_n_o(byte_en_n)
  );

endmodule

// File: tb/tb_mram_seq_ctrl.sv
// Scoreboard bench: two sequencer instances (default and widened parameters) share stimulus.
module tb_mram_seq_ctrl;

  localparam int unsigned P1_DW = 32, P1_AW = 24, P1_RW = 3, P1_WP = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rws = 1'b0, abort = 1'b0;
  logic [3:0] bsel = '0;

  logic b0, d0, de0, ae0, sd0, ld0, pe0, ce0, we0, oe0;
  logic b1, d1, de1, ae1, sd1, ld1, pe1, ce1, we1, oe1;
  logic [1:0] ben0;
  logic [3:0] ben1;

  always #5 clk = ~clk;

  mram_seq_ctrl #(.DATA_W(16), .ADDR_W(20), .RD_WAIT(1), .WR_PULSE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .read_write_sel(rws), .byte_sel(bsel[1:0]),
    .abort(abort), .busy(b0), .done(d0), .data_en(de0), .addr_en(ae0), .send_data(sd0),
    .load(ld0), .data_in_from_MRAM_en(pe0), .chip_en(ce0), .write_en(we0), .out_en(oe0),
    .byte_en_n(ben0));

  mram_seq_ctrl #(.DATA_W(P1_DW), .ADDR_W(P1_AW), .RD_WAIT(P1_RW), .WR_PULSE(P1_WP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .read_write_sel(rws), .byte_sel(bsel),
    .abort(abort), .busy(b1), .done(d1), .data_en(de1), .addr_en(ae1), .send_data(sd1),
    .load(ld1), .data_in_from_MRAM_en(pe1), .chip_en(ce1), .write_en(we1), .out_en(oe1),
    .byte_en_n(ben1));

  typedef struct {
    bit          wr;
    logic [3:0]  mask;
    int unsigned n;
  } rec_t;

  rec_t q0[$], q1[$];
  int total = 0, bad = 0;
  int unsigned rem [2];
  bit          m_busy [2];
  int unsigned m_cyc [2];
  int unsigned m_cnt [2][10];
  int unsigned m_first [2][10];

  function automatic int unsigned p_aw(int i); return i ? P1_AW : 20; endfunction
  function automatic int unsigned p_dw(int i); return i ? P1_DW : 16; endfunction
  function automatic int unsigned p_rw(int i); return i ? P1_RW : 1;  endfunction
  function automatic int unsigned p_wp(int i); return i ? P1_WP : 1;  endfunction

  function automatic int unsigned lat(int i, bit wr);
    int unsigned s;
    s = (p_aw(i) > p_dw(i)) ? p_aw(i) : p_dw(i);
    return wr ? s + p_wp(i) + 1 : p_aw(i) + p_rw(i) + p_dw(i) + 3;
  endfunction

  // Signal index: 0 busy, 1 done, 2 addr_en, 3 data_en, 4 send_data, 5 load,
  // 6 pts_en, 7 chip_en low, 8 write_en low, 9 out_en low. Cycles count from 1 after accept.
  function automatic void ivals(int i, bit wr, int s, output int unsigned lo0, output int unsigned len0,
                                output int unsigned lo1, output int unsigned len1);
    int unsigned a, d, rw, wp, sh, l;
    a = p_aw(i); d = p_dw(i); rw = p_rw(i); wp = p_wp(i);
    sh = (a > d) ? a : d; l = lat(i, wr);
    lo0 = 0; len0 = 0; lo1 = 0; len1 = 0;
    case (s)
      0: begin lo0 = 1; len0 = l; end
      1: begin lo0 = l; len0 = 1; end
      2: begin lo0 = 1; len0 = a; end
      3: if (wr) begin lo0 = 1; len0 = d; end
      4: if (wr) begin lo0 = sh + 1; len0 = wp; end
         else begin lo0 = a + 1; len0 = rw + 1; lo1 = a + rw + 3; len1 = d; end
      5: if (!wr) begin lo0 = a + rw + 2; len0 = 1; end
      6: if (!wr) begin lo0 = a + rw + 2; len0 = d + 1; end
      7: if (wr) begin lo0 = sh + 1; len0 = wp; end
         else begin lo0 = a + 1; len0 = rw + 2; end
      8: if (wr) begin lo0 = sh + 1; len0 = wp; end
      9: if (!wr) begin lo0 = a + 1; len0 = rw + 2; end
      default: ;
    endcase
  endfunction

  function automatic int unsigned ov(int unsigned lo, int unsigned len, int unsigned n);
    int unsigned hi;
    if (len == 0 || lo > n) return 0;
    hi = lo + len - 1;
    if (hi > n) hi = n;
    return hi - lo + 1;
  endfunction

  function automatic logic [9:0] obs(int i);
    if (i == 1) return {~oe1, ~we1, ~ce1, pe1, ld1, sd1, de1, ae1, d1, b1};
    return {~oe0, ~we0, ~ce0, pe0, ld0, sd0, de0, ae0, d0, b0};
  endfunction

  function automatic int qsize(int i); return i ? q1.size() : q0.size(); endfunction
  function automatic rec_t qfront(int i); return i ? q1[0] : q0[0]; endfunction
  function automatic rec_t qpop(int i);
    if (i == 1) return q1.pop_front();
    return q0.pop_front();
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(bit wr, logic [3:0] m);
    start = 1'b1; rws = wr; bsel = m;
    cyc(1);
    start = 1'b0;
  endtask

  // Reference model: accepts, tracks how long each op stays busy, truncates on abort.
  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      rec_t r;
      if (!rst_n) begin
        rem[i] = 0;
        if (i == 1) q1.delete(); else q0.delete();
      end else if (rem[i] == 0) begin
        if (start && !abort) begin
          r.wr = rws;
          r.mask = (i == 1) ? bsel : {2'b00, bsel[1:0]};
          if (i == 0 && bsel[1:0] == 2'b00) r.mask = 4'h3;
          if (i == 1 && bsel == 4'h0) r.mask = 4'hF;
          r.n = lat(i, rws);
          rem[i] = r.n;
          if (i == 1) q1.push_back(r); else q0.push_back(r);
        end
      end else if (abort && rem[i] > 1) begin
        if (qsize(i) > 0) begin
          if (i == 1) r = q1.pop_back(); else r = q0.pop_back();
          r.n = r.n - rem[i] + 1;
          if (i == 1) q1.push_back(r); else q0.push_back(r);
        end
        rem[i] = 0;
      end else begin
        rem[i]--;
      end
    end
  end

  // Monitor: profiles each busy window and scores it when busy drops.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [9:0] ob;
      logic [3:0] ben, eben;
      rec_t r;
      int unsigned lo0, len0, lo1, len1, ec, ef;
      ob = obs(i);
      ben = (i == 1) ? ben1 : {2'b11, ben0};
      if (!rst_n) begin
        m_busy[i] = 0; m_cyc[i] = 0;
        for (int s = 0; s < 10; s++) begin m_cnt[i][s] = 0; m_first[i][s] = 0; end
      end else if (ob[0]) begin
        m_cyc[i]++;
        for (int s = 0; s < 10; s++)
          if (ob[s]) begin
            m_cnt[i][s]++;
            if (m_first[i][s] == 0) m_first[i][s] = m_cyc[i];
          end
        if (qsize(i) > 0) begin
          r = qfront(i);
          eben = ob[7] ? ~r.mask : 4'hF;
          if (i == 0) eben[3:2] = 2'b11;
          check($sformatf("i%0d_byte_en_n_c%0d", i, m_cyc[i]), 64'(ben), 64'(eben));
        end
        m_busy[i] = 1;
      end else if (m_busy[i]) begin
        check($sformatf("i%0d_idle_outputs", i), 64'({ob, ben}), 64'({10'b0, 4'hF}));
        if (qsize(i) == 0) begin
          total++; bad++;
          $display("FAIL i%0d_unexpected_op actual=busy required=idle", i);
        end else begin
          r = qpop(i);
          check($sformatf("i%0d_busy_len", i), 64'(m_cyc[i]), 64'(r.n));
          for (int s = 1; s < 10; s++) begin
            ivals(i, r.wr, s, lo0, len0, lo1, len1);
            ec = ov(lo0, len0, r.n) + ov(lo1, len1, r.n);
            ef = (len0 > 0 && lo0 <= r.n) ? lo0 : ((len1 > 0 && lo1 <= r.n) ? lo1 : 0);
            check($sformatf("i%0d_wr%0d_sig%0d_count", i, r.wr, s), 64'(m_cnt[i][s]), 64'(ec));
            check($sformatf("i%0d_wr%0d_sig%0d_first", i, r.wr, s), 64'(m_first[i][s]), 64'(ef));
          end
        end
        m_busy[i] = 0; m_cyc[i] = 0;
        for (int s = 0; s < 10; s++) begin m_cnt[i][s] = 0; m_first[i][s] = 0; end
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (t < 400 && !(rem[0] == 0 && rem[1] == 0 && q0.size() == 0 && q1.size() == 0 &&
                        !m_busy[0] && !m_busy[1])) begin
      cyc(1);
      t++;
    end
    check("drain_idle", 64'(t < 400), 64'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_i0"}, 64'({b0, d0, de0, ae0, sd0, ld0, pe0, ce0, we0, oe0, ben0}), 64'h01F);
    check({tag, "_i1"}, 64'({b1, d1, de1, ae1, sd1, ld1, pe1, ce1, we1, oe1, ben1}), 64'h07F);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(2);

    op(1'b1, 4'b0011); cyc(70);
    op(1'b0, 4'b0001); cyc(70);
    op(1'b1, 4'b0000); cyc(70);

    op(1'b0, 4'b0001); cyc(9);
    abort = 1'b1; cyc(1); abort = 1'b0;
    cyc(2);
    op(1'b0, 4'b0001); cyc(70);

    op(1'b1, 4'b0011); cyc(4);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(70);
    start = 1'b1; abort = 1'b1; cyc(1); start = 1'b0; abort = 1'b0;
    cyc(5);

    start = 1'b1; rws = 1'b1; bsel = 4'b0010;
    cyc(150);
    start = 1'b0;
    cyc(70);

    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      rws   = 1'($urandom_range(0, 1));
      bsel  = 4'($urandom_range(0, 15));
      cyc(1);
    end
    start = 1'b0; abort = 1'b0;
    drain();

    op(1'b1, 4'b0011); cyc(20);
    check("pre_reset_chip_en", 64'(ce0), 64'd0);
    check("pre_reset_write_en", 64'(we0), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_chip_en", 64'(ce0), 64'd1);
    check("async_write_en", 64'(we0), 64'd1);
    check("async_busy", 64'(b0), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check_reset_outputs("post_reset");
    op(1'b0, 4'b0010); cyc(70);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
